// File: rtl/dram_arb_pkg.sv
// Shared state/owner encodings and default widths for the DRAM arbiter.
package dram_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CORE = 2'b01;
  localparam logic [1:0] ST_DMA  = 2'b10;

  // The state encoding doubles as the owner code presented on the owner port.
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CORE = ST_CORE,
    DMA  = ST_DMA
  } state_t;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  localparam logic [15:0] BCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mux2to1.sv
// Generic two-input select; b is chosen when sel is high.
module mux2to1 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/dram_arbiter.sv
// Core/DMA arbiter in front of the single-port DRAM: registered grants,
// round-robin tie-break, optional burst limit, and per-port read-valid tags.
//
// state | meaning
// IDLE  | nobody owns DRAM, m_* driven to zero
// CORE  | core port owns DRAM this cycle
// DMA   | DMA port owns DRAM this cycle
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_din,
  input  logic          c_we,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_din,
  input  logic          d_we,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  output logic          m_we,
  input  logic [DW-1:0] m_dout,
  output logic [DW-1:0] rdata,
  output logic [1:0]    owner
);

  localparam int MW = AW + DW + 1;
  // Terminal count of the burst counter; unused when the limit is disabled.
  localparam logic [15:0] BURST_TC = (MAX_BURST == 0) ? 16'd0 : 16'(MAX_BURST - 1);

  state_t        state, state_nxt, last;
  logic [15:0]   bcnt;
  logic          rv_c, rv_d;
  logic          burst_hit;
  logic [MW-1:0] mux_y;
  logic [MW-1:0] m_bus;

  assign burst_hit = (MAX_BURST != 0) && (bcnt == BURST_TC);

  // Next owner: hand over directly on req drop, preempt at the burst limit.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (c_req && d_req) state_nxt = (last == CORE) ? DMA : CORE;
        else if (c_req)     state_nxt = CORE;
        else if (d_req)     state_nxt = DMA;
      end
      CORE: begin
        if (!c_req)                 state_nxt = d_req ? DMA : IDLE;
        else if (burst_hit && d_req) state_nxt = DMA;
      end
      DMA: begin
        if (!d_req)                 state_nxt = c_req ? CORE : IDLE;
        else if (burst_hit && c_req) state_nxt = CORE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, last owner and saturating burst counter (cleared on any change).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= DMA;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        bcnt <= '0;
        if (state_nxt != IDLE) last <= state_nxt;
      end else if (state != IDLE && bcnt != BCNT_MAX) begin
        bcnt <= bcnt + 16'd1;
      end
    end
  end

  // Tag next cycle's DRAM read data with the port that issued the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rv_c <= 1'b0;
      rv_d <= 1'b0;
    end else begin
      rv_c <= c_gnt & ~c_we;
      rv_d <= d_gnt & ~d_we;
    end
  end

  assign c_gnt = (state == CORE);
  assign d_gnt = (state == DMA);
  assign owner = state;

  mux2to1 #(.W(MW)) u_mux (
    .sel (d_gnt),
    .a   ({c_addr, c_din, c_we}),
    .b   ({d_addr, d_din, d_we}),
    .y   (mux_y)
  );

  // Without a grant the DRAM sees all zeros, so m_we can never fire ungranted.
  assign m_bus = mux_y & {MW{c_gnt | d_gnt}};
  assign {m_addr, m_din, m_we} = m_bus;

  assign rdata    = m_dout;
  assign c_rvalid = rv_c;
  assign d_rvalid = rv_d;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: two instances (burst limit 4 and unlimited), each with
// its own DRAM model, per-port access queues, an ownership reference model and a
// read-data scoreboard popped by an independent monitor.
module tb_dram_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int MB = (g == 0) ? 4 : 0;

    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [15:0] c_addr, d_addr, m_addr;
    logic [7:0]  c_din, d_din, m_din, m_dout, rdata;
    logic        m_we;
    logic [1:0]  owner;

    acc_t        cq[$];
    acc_t        dq[$];
    logic [7:0]  c_exp[$];
    logic [7:0]  d_exp[$];
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          m_own, m_last, m_run;
    int          gap_pct = 0;
    logic        done = 1'b0;

    dram_arbiter #(.AW(16), .DW(8), .MAX_BURST(MB)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_addr(c_addr), .c_din(c_din), .c_we(c_we),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .d_req(d_req), .d_addr(d_addr), .d_din(d_din), .d_we(d_we),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout),
      .rdata(rdata), .owner(owner)
    );

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk($sformatf("mb%0d_%s", MB, name), act, exp);
    endtask

    task automatic push_c(input logic [15:0] a, input logic [7:0] d, input logic w);
      cq.push_back(acc_t'{a, d, w});
    endtask

    task automatic push_d(input logic [15:0] a, input logic [7:0] d, input logic w);
      dq.push_back(acc_t'{a, d, w});
    endtask

    task automatic drain(input int budget);
      int n;
      n = 0;
      while ((cq.size() != 0 || dq.size() != 0) && n < budget) begin
        @(posedge clk);
        n++;
      end
      ck("drain_done", cq.size() + dq.size(), 0);
      repeat (3) @(posedge clk);
    endtask

    // DRAM model: synchronous read with one cycle of latency.
    initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
      forever begin
        @(posedge clk);
        m_dout <= mem[m_addr];
        if (m_we) mem[m_addr] <= m_din;
      end
    end

    // Masters plus reference model: who must own DRAM, what DRAM must see,
    // and what each read must return.
    initial begin
      int   nxt;
      logic own_req, oth_req, c_cmp, d_cmp;
      c_req = 1'b0; c_addr = '0; c_din = '0; c_we = 1'b0;
      d_req = 1'b0; d_addr = '0; d_din = '0; d_we = 1'b0;
      m_own = 0; m_last = 2; m_run = 0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
      forever begin
        @(negedge clk);
        c_cmp = 1'b0;
        d_cmp = 1'b0;
        if (!rst) begin
          m_own = 0; m_last = 2; m_run = 0;
        end
        ck("gnt_owner", {c_gnt, d_gnt, owner}, {m_own == 1, m_own == 2, 2'(m_own)});
        ck("dram_port", {m_we, m_addr, m_din},
           (m_own == 1) ? {c_we, c_addr, c_din} :
           (m_own == 2) ? {d_we, d_addr, d_din} : 25'd0);
        if (rst) begin
          if (m_own == 1) begin
            if (c_we) ref_mem[c_addr] = c_din;
            else      c_exp.push_back(ref_mem[c_addr]);
          end else if (m_own == 2) begin
            if (d_we) ref_mem[d_addr] = d_din;
            else      d_exp.push_back(ref_mem[d_addr]);
          end
          c_cmp = c_gnt & c_req;
          d_cmp = d_gnt & d_req;
          if (c_cmp && cq.size() != 0) void'(cq.pop_front());
          if (d_cmp && dq.size() != 0) void'(dq.pop_front());

          if (m_own == 0) begin
            nxt = (c_req && d_req) ? 3 - m_last : c_req ? 1 : d_req ? 2 : 0;
          end else begin
            own_req = (m_own == 1) ? c_req : d_req;
            oth_req = (m_own == 1) ? d_req : c_req;
            if (!own_req)                                  nxt = oth_req ? 3 - m_own : 0;
            else if (MB != 0 && m_run + 1 == MB && oth_req) nxt = 3 - m_own;
            else                                           nxt = m_own;
          end
          if (nxt != m_own) begin
            m_run = 0;
            if (nxt != 0) m_last = nxt;
          end else if (nxt != 0) begin
            m_run++;
          end
          m_own = nxt;
        end

        @(posedge clk);
        #1;
        if (!rst) begin
          c_req = 1'b0; c_we = 1'b0;
          d_req = 1'b0; d_we = 1'b0;
        end else begin
          if (cq.size() != 0 && ((c_req && !c_cmp) || $urandom_range(0, 99) >= gap_pct)) begin
            c_req = 1'b1;
            {c_addr, c_din, c_we} = cq[0];
          end else begin
            c_req = 1'b0;
          end
          if (dq.size() != 0 && ((d_req && !d_cmp) || $urandom_range(0, 99) >= gap_pct)) begin
            d_req = 1'b1;
            {d_addr, d_din, d_we} = dq[0];
          end else begin
            d_req = 1'b0;
          end
        end
      end
    end

    // Read-return monitor: pops the expected byte whenever a port's rvalid is up.
    initial forever begin
      @(negedge clk);
      if (c_rvalid || d_rvalid) ck("rvalid_exclusive", c_rvalid & d_rvalid, 0);
      if (c_rvalid) begin
        if (c_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL mb%0d_c_rvalid: got rvalid with no read pending, expected none", MB);
        end else begin
          ck("c_rdata", rdata, c_exp.pop_front());
        end
      end
      if (d_rvalid) begin
        if (d_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL mb%0d_d_rvalid: got rvalid with no read pending, expected none", MB);
        end else begin
          ck("d_rdata", rdata, d_exp.pop_front());
        end
      end
    end

    // Scenario sequence.
    initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;

      // Simultaneous first requests: core wins, DMA follows without a gap.
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) push_c(16'h0100 + 16'(i), 8'hC0 + 8'(i), 1'b1);
      for (int i = 0; i < 3; i++) push_d(16'h0110 + 16'(i), 8'hD0 + 8'(i), 1'b1);
      push_d(16'h0100, 8'h00, 1'b0);
      drain(200);

      // Core alone: write then read back.
      @(posedge clk); #2;
      push_c(16'h0030, 8'h5A, 1'b1);
      push_c(16'h0030, 8'h00, 1'b0);
      drain(200);
      ck("core_wr_5a", mem[16'h0030], 8'h5A);

      // Async reset in the middle of a DMA write burst.
      @(posedge clk); #2;
      for (int i = 0; i < 8; i++) push_d(16'h0140 + 16'(i), 8'h77, 1'b1);
      for (int i = 0; i < 60 && !(d_gnt && m_we); i++) begin
        @(posedge clk); #2;
      end
      ck("rst_trigger", d_gnt & m_we, 1);
      rst = 1'b0;
      #1;
      ck("rst_outputs", {c_gnt, d_gnt, c_rvalid, d_rvalid, m_we, m_addr, m_din, owner}, 0);
      cq.delete(); dq.delete(); c_exp.delete(); d_exp.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #2;
      push_c(16'h0030, 8'h00, 1'b0);
      drain(200);

      // DMA burst of 16 writes against a core that keeps requesting.
      @(posedge clk); #2;
      for (int i = 0; i < 16; i++) push_d(16'h0030 + 16'(i), 8'(16 - i), 1'b1);
      for (int i = 0; i < 24; i++) push_c(16'h0020 + 16'($urandom_range(0, 31)), 8'h00, 1'b0);
      drain(400);
      for (int i = 0; i < 16; i++) ck($sformatf("burst_mem_%0d", i), mem[16'h0030 + 16'(i)], 8'(16 - i));

      // DMA holds req for 20 reads while the core waits.
      @(posedge clk); #2;
      for (int i = 0; i < 20; i++) push_d(16'h0020 + 16'(i % 16), 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) push_c(16'h0050 + 16'(i), 8'hE0 + 8'(i), 1'b1);
      drain(400);

      // Random mixed traffic with request gaps over a small shared window.
      gap_pct = 30;
      @(posedge clk); #2;
      for (int i = 0; i < 150; i++) begin
        push_c(16'h0200 + 16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)));
        push_d(16'h0200 + 16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      drain(5000);

      ck("c_reads_left", c_exp.size(), 0);
      ck("d_reads_left", d_exp.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(h[0].done && h[1].done) && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    chk("run_complete", {30'b0, h[1].done, h[0].done}, 32'h3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
